uart_rx_fsm: RTL and testbench
==============================

// Module: uart_rx_fsm
// PURPOSE
//   Receive-side state machine of the self-defined UART core. Counterpart of the TX FSM.
//   Oversamples the serial line, detects and qualifies the start bit, and shifts in LSB-first data.
//   Optionally checks parity, then checks the stop bit.
//   Delivers each byte to the RX FIFO with a one-cycle valid pulse plus error flags.
//   State register and bit counter are triplicated (A/B/C) with majority voting.
// PARAMETERS
//   OVERSAMPLE  16  p_SampleSig_i ticks per bit time; even, 4..16
//   BITNUMBER   8   data bits per frame, 5..8
// PORTS
//   clk              in   1  system clock, >=40MHz
//   rst              in   1  asynchronous active-low reset, released synchronously with clk
//   p_SampleSig_i    in   1  oversample tick from the baudrate module, 1 clk wide, OVERSAMPLE per bit
//   Rx_i             in   1  serial line, asynchronous to clk, idle high
//   ParityEnable_i   in   1  1 = a parity bit follows the data bits
//   ParityOdd_i      in   1  1 = odd parity, 0 = even parity
//   p_FiFoFull_i     in   1  RX FIFO full
//   Data_o           out  8  last received byte, right-aligned, upper bits 0 when BITNUMBER<8
//   p_DataValid_o    out  1  1-clk pulse: Data_o holds a new byte, write it to the FIFO
//   p_ParityErr_o    out  1  1-clk pulse: parity mismatch on the current byte
//   p_FrameErr_o     out  1  1-clk pulse: stop bit sampled low
//   p_Overrun_o      out  1  1-clk pulse: byte dropped because the FIFO was full
//   State_o          out  5  voted one-hot state
//   BitCounter_o     out  4  voted count of data bits received in the current frame
// BEHAVIOUR
//   Reset: state=IDLE; bit and sample counters=0; Data_o=0; all pulses=0; Rx sync flops=1.
//   Reset mid-frame aborts the frame and produces no pulses.
//   Rx_i passes through a 2-FF synchronizer (rx_s). All sampling uses rx_s.
//   Sample counter (scnt) advances only on p_SampleSig_i.
//   States (one-hot): IDLE 00001, STARTBIT 00010, DATABITS 00100, PARITYBIT 01000, STOPBIT 10000.
//   IDLE:
//     On a tick with rx_s=0 and armed=1: go to STARTBIT, scnt=0.
//     armed clears after a frame error and sets again on any tick with rx_s=1.
//   STARTBIT:
//     On the tick where scnt==OVERSAMPLE/2-1 (mid-bit), check rx_s.
//     rx_s=1: false start, return to IDLE, no output.
//     rx_s=0: go to DATABITS, scnt=0, latch ParityEnable_i/ParityOdd_i for the whole frame.
//   DATABITS:
//     On the tick where scnt==OVERSAMPLE-1: shift rx_s in LSB-first, bitcnt+1, scnt=0.
//     After bit BITNUMBER: go to PARITYBIT if parity is latched enabled, otherwise STOPBIT.
//   PARITYBIT:
//     On the tick where scnt==OVERSAMPLE-1: perr = rx_s ^ (^data) ^ odd; go to STOPBIT.
//   STOPBIT:
//     On the tick where scnt==OVERSAMPLE-1, go to IDLE and bitcnt=0.
//     In the next clk:
//       Data_o is updated.
//       p_DataValid_o=1 unless p_FiFoFull_i=1 at that tick; in that case p_Overrun_o=1 instead.
//       p_ParityErr_o=perr.
//       p_FrameErr_o=~rx_s; a frame error also clears armed.
//     Data_o is updated even on error or overrun.
//   Latency: stop-bit mid-sample tick -> pulses 1 clk later.
//     Earliest next start detection is the following tick.
//   Between ticks, state and counters hold.
//   Ticks arriving on consecutive clks are legal; each one counts.
//   TMR: each copy is written with the same next value, computed from the voted values.
//     A voted state that is not one-hot goes to IDLE on the next clk.
//     Voted bitcnt >= BITNUMBER while in DATABITS is treated as the last bit.
// TESTING
//   T1 OVERSAMPLE=16, 0xA5, no parity -> Data_o=0xA5, one p_DataValid_o, no errors, State_o back to 00001.
//   T2 0x3C, even parity: parity bit 0 -> valid, no error; parity bit 1 -> valid plus p_ParityErr_o, Data_o=0x3C.
//   T3 Rx low 4 ticks then high -> IDLE at tick 8, no pulses; a 0x55 frame sent next is received correctly.
//   T4 Rx held low 20 bit times -> exactly one p_FrameErr_o with Data_o=0x00; no new frame until Rx goes high.
//   T5 p_FiFoFull_i=1 at the stop sample of 0x81 -> p_Overrun_o pulse, no p_DataValid_o, Data_o=0x81.
//   T6 rst low during data bit 4, then force state_B_r=STOPBIT mid-frame of 0x0F
//      -> reset clears all outputs; 0x0F is still received correctly.

Source files
------------

// File: rtl/uart_rx_fsm.sv
// UART receive FSM: 2-FF line sync, oversampled start/data/parity/stop,
// triplicated state and bit counter with majority voting.
module uart_rx_fsm #(
  parameter int OVERSAMPLE = 16,
  parameter int BITNUMBER  = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       p_SampleSig_i,
  input  logic       Rx_i,
  input  logic       ParityEnable_i,
  input  logic       ParityOdd_i,
  input  logic       p_FiFoFull_i,
  output logic [7:0] Data_o,
  output logic       p_DataValid_o,
  output logic       p_ParityErr_o,
  output logic       p_FrameErr_o,
  output logic       p_Overrun_o,
  output logic [4:0] State_o,
  output logic [3:0] BitCounter_o
);

  typedef enum logic [4:0] {
    IDLE      = 5'b00001,
    STARTBIT  = 5'b00010,
    DATABITS  = 5'b00100,
    PARITYBIT = 5'b01000,
    STOPBIT   = 5'b10000
  } state_t;

  localparam logic [3:0] SMID  = 4'(OVERSAMPLE / 2 - 1);
  localparam logic [3:0] SLAST = 4'(OVERSAMPLE - 1);
  localparam logic [3:0] NBITS = 4'(BITNUMBER);
  localparam logic [3:0] LASTB = 4'(BITNUMBER - 1);
  localparam int         SH    = 8 - BITNUMBER;

  logic       rx_m;
  logic       rx_s;
  logic [4:0] state_A_r;
  logic [4:0] state_B_r;
  logic [4:0] state_C_r;
  logic [4:0] state_v;
  logic [3:0] bitcnt_A_r;
  logic [3:0] bitcnt_B_r;
  logic [3:0] bitcnt_C_r;
  logic [3:0] bitcnt_v;
  logic [3:0] scnt;
  logic [7:0] shreg;
  logic [7:0] data_al;
  logic       armed;
  logic       par_en;
  logic       par_odd;
  logic       perr;
  logic       onehot;
  logic       tick;
  state_t     state_n;
  logic [3:0] bitcnt_n;

  assign state_v  = (state_A_r & state_B_r) |
                    (state_B_r & state_C_r) |
                    (state_A_r & state_C_r);
  assign bitcnt_v = (bitcnt_A_r & bitcnt_B_r) |
                    (bitcnt_B_r & bitcnt_C_r) |
                    (bitcnt_A_r & bitcnt_C_r);
  assign onehot   = (state_v != 5'd0) &&
                    ((state_v & (state_v - 5'd1)) == 5'd0);
  assign tick     = p_SampleSig_i;
  assign data_al  = shreg >> SH;

  assign State_o      = state_v;
  assign BitCounter_o = bitcnt_v;

  // Bring the asynchronous serial line into the clk domain.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= Rx_i;
      rx_s <= rx_m;
    end
  end

  // Next state and bit count, derived from the voted copies.
  always_comb begin
    state_n  = state_t'(state_v);
    bitcnt_n = bitcnt_v;
    if (!onehot) begin
      state_n  = IDLE;
      bitcnt_n = 4'd0;
    end else if (tick) begin
      unique case (1'b1)
        state_v[0]: begin
          bitcnt_n = 4'd0;
          if (!rx_s && armed)
            state_n = STARTBIT;
        end
        state_v[1]: begin
          bitcnt_n = 4'd0;
          if (scnt == SMID)
            state_n = rx_s ? IDLE : DATABITS;
        end
        state_v[2]: begin
          if (scnt == SLAST) begin
            bitcnt_n = (bitcnt_v >= NBITS) ? NBITS
                                           : bitcnt_v + 4'd1;
            if (bitcnt_v >= LASTB)
              state_n = par_en ? PARITYBIT : STOPBIT;
          end
        end
        state_v[3]: begin
          if (scnt == SLAST)
            state_n = STOPBIT;
        end
        state_v[4]: begin
          if (scnt == SLAST) begin
            state_n  = IDLE;
            bitcnt_n = 4'd0;
          end
        end
        default: ;
      endcase
    end
  end

  // All three copies take the same voted-derived next value.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_A_r  <= IDLE;
      state_B_r  <= IDLE;
      state_C_r  <= IDLE;
      bitcnt_A_r <= 4'd0;
      bitcnt_B_r <= 4'd0;
      bitcnt_C_r <= 4'd0;
    end else begin
      state_A_r  <= state_n;
      state_B_r  <= state_n;
      state_C_r  <= state_n;
      bitcnt_A_r <= bitcnt_n;
      bitcnt_B_r <= bitcnt_n;
      bitcnt_C_r <= bitcnt_n;
    end
  end

  // Sample counter, data shifting, parity and the result pulses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scnt          <= 4'd0;
      shreg         <= 8'd0;
      armed         <= 1'b1;
      par_en        <= 1'b0;
      par_odd       <= 1'b0;
      perr          <= 1'b0;
      Data_o        <= 8'd0;
      p_DataValid_o <= 1'b0;
      p_ParityErr_o <= 1'b0;
      p_FrameErr_o  <= 1'b0;
      p_Overrun_o   <= 1'b0;
    end else begin
      p_DataValid_o <= 1'b0;
      p_ParityErr_o <= 1'b0;
      p_FrameErr_o  <= 1'b0;
      p_Overrun_o   <= 1'b0;
      if (!onehot) begin
        scnt <= 4'd0;
      end else if (tick) begin
        if (rx_s)
          armed <= 1'b1;
        unique case (1'b1)
          state_v[0]: begin
            scnt <= 4'd0;
          end
          state_v[1]: begin
            if (scnt == SMID) begin
              scnt <= 4'd0;
              if (!rx_s) begin
                par_en  <= ParityEnable_i;
                par_odd <= ParityOdd_i;
                shreg   <= 8'd0;
                perr    <= 1'b0;
              end
            end else begin
              scnt <= scnt + 4'd1;
            end
          end
          state_v[2]: begin
            if (scnt == SLAST) begin
              scnt  <= 4'd0;
              shreg <= {rx_s, shreg[7:1]};
            end else begin
              scnt <= scnt + 4'd1;
            end
          end
          state_v[3]: begin
            if (scnt == SLAST) begin
              scnt <= 4'd0;
              perr <= rx_s ^ (^data_al) ^ par_odd;
            end else begin
              scnt <= scnt + 4'd1;
            end
          end
          state_v[4]: begin
            if (scnt == SLAST) begin
              scnt          <= 4'd0;
              Data_o        <= data_al;
              p_DataValid_o <= ~p_FiFoFull_i;
              p_Overrun_o   <= p_FiFoFull_i;
              p_ParityErr_o <= perr;
              p_FrameErr_o  <= ~rx_s;
              if (!rx_s)
                armed <= 1'b0;
            end else begin
              scnt <= scnt + 4'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_fsm.sv
// Directed bench for uart_rx_fsm: tick every 2 clks, 16 ticks per bit,
// so one bit time is 32 clks.
module tb_uart_rx_fsm;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       tick = 1'b0;
  logic       rx = 1'b1;
  logic       par_en = 1'b0;
  logic       par_odd = 1'b0;
  logic       full = 1'b0;
  logic [7:0] data;
  logic       dv;
  logic       pe;
  logic       fe;
  logic       ov;
  logic [4:0] st;
  logic [3:0] bc;

  int total = 0;
  int bad   = 0;
  int n_dv  = 0;
  int n_pe  = 0;
  int n_fe  = 0;
  int n_ov  = 0;
  int b_dv, b_pe, b_fe, b_ov;

  localparam int BT = 32;

  uart_rx_fsm #(.OVERSAMPLE(16), .BITNUMBER(8)) dut (
    .clk           (clk),
    .rst           (rst),
    .p_SampleSig_i (tick),
    .Rx_i          (rx),
    .ParityEnable_i(par_en),
    .ParityOdd_i   (par_odd),
    .p_FiFoFull_i  (full),
    .Data_o        (data),
    .p_DataValid_o (dv),
    .p_ParityErr_o (pe),
    .p_FrameErr_o  (fe),
    .p_Overrun_o   (ov),
    .State_o       (st),
    .BitCounter_o  (bc)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(negedge clk);
    tick = ~tick;
  end

  always @(negedge clk) begin
    if (dv) n_dv++;
    if (pe) n_pe++;
    if (fe) n_fe++;
    if (ov) n_ov++;
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic mark();
    b_dv = n_dv;
    b_pe = n_pe;
    b_fe = n_fe;
    b_ov = n_ov;
  endtask

  task automatic pulses(input string tag,
                        input int edv, input int epe,
                        input int efe, input int eov);
    chk({tag, "_dv"}, n_dv - b_dv, edv);
    chk({tag, "_pe"}, n_pe - b_pe, epe);
    chk({tag, "_fe"}, n_fe - b_fe, efe);
    chk({tag, "_ov"}, n_ov - b_ov, eov);
  endtask

  task automatic send_bit(input logic b);
    rx = b;
    repeat (BT) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d,
                            input bit       pon,
                            input logic     pbit,
                            input bit       look);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++)
      send_bit(d[i]);
    if (pon)
      send_bit(pbit);
    if (look && !pon) begin
      chk("stop_state", st, 5'b10000);
      chk("stop_bitcnt", bc, 4'd8);
    end
    send_bit(1'b1);
    send_bit(1'b1);
  endtask

  initial begin
    repeat (4) @(negedge clk);
    chk("rst_state", st, 5'b00001);
    chk("rst_data", data, 8'h00);
    chk("rst_bitcnt", bc, 4'd0);
    chk("rst_pulses", {dv, pe, fe, ov}, 4'b0000);
    rst = 1'b1;
    repeat (BT) @(negedge clk);

    mark();
    send_frame(8'hA5, 0, 1'b0, 1);
    chk("t1_data", data, 8'hA5);
    chk("t1_state", st, 5'b00001);
    pulses("t1", 1, 0, 0, 0);

    par_en = 1'b1;
    par_odd = 1'b0;
    mark();
    send_frame(8'h3C, 1, 1'b0, 0);
    chk("t2a_data", data, 8'h3C);
    pulses("t2a", 1, 0, 0, 0);
    mark();
    send_frame(8'h3C, 1, 1'b1, 0);
    chk("t2b_data", data, 8'h3C);
    pulses("t2b", 1, 1, 0, 0);
    par_odd = 1'b1;
    mark();
    send_frame(8'h3C, 1, 1'b1, 0);
    pulses("t2c", 1, 0, 0, 0);
    par_en = 1'b0;
    par_odd = 1'b0;

    mark();
    rx = 1'b0;
    repeat (8) @(negedge clk);
    rx = 1'b1;
    repeat (40) @(negedge clk);
    chk("t3_idle", st, 5'b00001);
    pulses("t3_false", 0, 0, 0, 0);
    mark();
    send_frame(8'h55, 0, 1'b0, 0);
    chk("t3_data", data, 8'h55);
    pulses("t3", 1, 0, 0, 0);

    mark();
    rx = 1'b0;
    repeat (20 * BT) @(negedge clk);
    chk("t4_data", data, 8'h00);
    chk("t4_state", st, 5'b00001);
    pulses("t4", 1, 0, 1, 0);
    rx = 1'b1;
    repeat (2 * BT) @(negedge clk);
    pulses("t4_after", 1, 0, 1, 0);

    mark();
    full = 1'b1;
    send_frame(8'h81, 0, 1'b0, 0);
    full = 1'b0;
    chk("t5_data", data, 8'h81);
    pulses("t5", 0, 0, 0, 1);

    mark();
    send_bit(1'b0);
    for (int i = 0; i < 4; i++)
      send_bit(1'b1);
    rx = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b0;
    rx = 1'b1;
    repeat (3) @(negedge clk);
    chk("t6_rst_data", data, 8'h00);
    chk("t6_rst_state", st, 5'b00001);
    chk("t6_rst_bitcnt", bc, 4'd0);
    rst = 1'b1;
    repeat (2 * BT) @(negedge clk);
    pulses("t6_abort", 0, 0, 0, 0);

    mark();
    fork
      send_frame(8'h0F, 0, 1'b0, 0);
      begin
        repeat (4 * BT + 5) @(negedge clk);
        force dut.state_B_r = 5'b10000;
        repeat (3) @(negedge clk);
        release dut.state_B_r;
      end
    join
    chk("t6_data", data, 8'h0F);
    chk("t6_state", st, 5'b00001);
    pulses("t6", 1, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
